// File: rtl/mic_filter_pkg.sv
// Shared constants and types for the microphone moving-average filter.
package mic_filter_pkg;

    localparam int DATA_W_DEF   = 16;
    localparam int LOG2_LEN_DEF = 4;
    localparam int LEN          = 2 ** LOG2_LEN_DEF;
    localparam int SUM_W        = DATA_W_DEF + LOG2_LEN_DEF;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

endpackage

// File: rtl/mic_sample_ring.sv
// Sample history ring: one synchronous write port, one asynchronous read
// port, no reset so the storage can map onto distributed RAM.
module mic_sample_ring #(
    parameter int DATA_W   = 16,
    parameter int LOG2_LEN = 4
) (
    input  logic                clk,
    input  logic                we_i,
    input  logic [LOG2_LEN-1:0] waddr_i,
    input  logic [DATA_W-1:0]   wdata_i,
    input  logic [LOG2_LEN-1:0] raddr_i,
    output logic [DATA_W-1:0]   rdata_o
);

    localparam int DEPTH = 2 ** LOG2_LEN;

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Write the addressed entry; contents are only ever zeroed by the clear sweep.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mic_moving_avg_filter.sv
// Boxcar low-pass for the microphone path: running sum over the last
// 2**LOG2_LEN accepted samples, divided by an arithmetic shift.
module mic_moving_avg_filter
    import mic_filter_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int LOG2_LEN = LOG2_LEN_DEF
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     soft_rst,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] in_data,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic signed [DATA_W-1:0] out_data,
    output logic                     primed
);

    localparam int DEPTH = 2 ** LOG2_LEN;
    localparam int ACC_W = DATA_W + LOG2_LEN;

    state_t                     state_q, state_d;
    logic [LOG2_LEN-1:0]        clr_ptr_q, clr_ptr_d;
    logic [LOG2_LEN-1:0]        wr_ptr_q, wr_ptr_d;
    logic signed [ACC_W-1:0]    sum_q, sum_d;
    logic [LOG2_LEN:0]          fill_cnt_q, fill_cnt_d;
    logic                       out_valid_q, out_valid_d;
    logic signed [DATA_W-1:0]   out_data_q, out_data_d;
    logic                       primed_q, primed_d;

    logic                       accept;
    logic                       ring_we;
    logic [LOG2_LEN-1:0]        ring_waddr;
    logic [DATA_W-1:0]          ring_wdata;
    logic [DATA_W-1:0]          ring_rdata;
    logic signed [ACC_W-1:0]    avg_full;

    // soft_rst gates ready directly so a sample presented with it is dropped.
    assign in_ready = (state_q == RUN) && !soft_rst;
    assign accept   = in_valid && in_ready;

    mic_sample_ring #(
        .DATA_W   (DATA_W),
        .LOG2_LEN (LOG2_LEN)
    ) u_ring (
        .clk     (clk),
        .we_i    (ring_we),
        .waddr_i (ring_waddr),
        .wdata_i (ring_wdata),
        .raddr_i (wr_ptr_q),
        .rdata_o (ring_rdata)
    );

    // Next-state: clear sweep, accumulate on accept, soft_rst overrides all.
    always_comb begin
        state_d     = state_q;
        clr_ptr_d   = clr_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        sum_d       = sum_q;
        fill_cnt_d  = fill_cnt_q;
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;
        primed_d    = primed_q;
        ring_we     = 1'b0;
        ring_waddr  = wr_ptr_q;
        ring_wdata  = in_data;
        avg_full    = '0;

        if (soft_rst) begin
            state_d    = CLEAR;
            clr_ptr_d  = '0;
            wr_ptr_d   = '0;
            sum_d      = '0;
            fill_cnt_d = '0;
            primed_d   = 1'b0;
        end else begin
            case (state_q)
                CLEAR: begin
                    ring_we    = 1'b1;
                    ring_waddr = clr_ptr_q;
                    ring_wdata = '0;
                    clr_ptr_d  = clr_ptr_q + 1'b1;
                    if (clr_ptr_q == LOG2_LEN'(DEPTH - 1)) begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (accept) begin
                        ring_we  = 1'b1;
                        // Old sample leaves the window as the new one enters.
                        sum_d    = sum_q
                                 + {{LOG2_LEN{in_data[DATA_W-1]}}, in_data}
                                 - {{LOG2_LEN{ring_rdata[DATA_W-1]}}, ring_rdata};
                        wr_ptr_d = wr_ptr_q + 1'b1;
                        if (fill_cnt_q != (LOG2_LEN+1)'(DEPTH)) begin
                            fill_cnt_d = fill_cnt_q + 1'b1;
                        end
                        primed_d    = (fill_cnt_d == (LOG2_LEN+1)'(DEPTH));
                        avg_full    = sum_d >>> LOG2_LEN;
                        out_valid_d = 1'b1;
                        out_data_d  = avg_full[DATA_W-1:0];
                    end
                end
                default: state_d = CLEAR;
            endcase
        end
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= CLEAR;
            clr_ptr_q   <= '0;
            wr_ptr_q    <= '0;
            sum_q       <= '0;
            fill_cnt_q  <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            primed_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_ptr_q   <= clr_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            sum_q       <= sum_d;
            fill_cnt_q  <= fill_cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            primed_q    <= primed_d;
        end
    end

    // A strobe landing in a cycle where soft_rst is raised is suppressed.
    assign out_valid = out_valid_q && !soft_rst;
    assign out_data  = out_data_q;
    assign primed    = primed_q;

endmodule

// File: tb/tb_mic_moving_avg_filter.sv
// Directed bench for the microphone moving-average filter: a window-of-samples
// model checked every cycle plus literal expectations from hand arithmetic.
module tb_mic_moving_avg_filter;

    localparam int DATA_W = 16;
    localparam int LEN    = 16;

    logic                     clk = 1'b0;
    logic                     reset_n;
    logic                     soft_rst;
    logic                     in_valid;
    logic signed [DATA_W-1:0] in_data;
    logic                     in_ready;
    logic                     out_valid;
    logic signed [DATA_W-1:0] out_data;
    logic                     primed;

    int errors = 0;
    int checks = 0;

    // Model state: cycles spent clearing, accepted-sample window, fill count.
    int m_clr  = 0;
    int m_fill = 0;
    int m_data = 0;
    bit m_pend = 1'b0;
    int hist[$];

    mic_moving_avg_filter #(
        .DATA_W   (DATA_W),
        .LOG2_LEN (4)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .soft_rst  (soft_rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .primed    (primed)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Average of the window with missing samples as zero, floored toward -inf.
    function automatic int window_avg(input int q[$]);
        int s = 0;
        foreach (q[i]) s += q[i];
        if (s >= 0) return s / LEN;
        return -((-s + LEN - 1) / LEN);
    endfunction

    // Per-cycle compare against the model, then advance the model on the
    // inputs that the next rising edge will see.
    initial begin
        bit acc;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                m_clr = 0; m_fill = 0; m_pend = 1'b0; m_data = 0;
                hist.delete();
            end
            chk("model_in_ready", int'(in_ready), int'(reset_n && m_clr >= LEN && !soft_rst));
            chk("model_out_valid", int'(out_valid), int'(m_pend && !soft_rst));
            chk("model_out_data", int'(out_data), m_data);
            chk("model_primed", int'(primed), int'(m_fill == LEN));
            if (reset_n) begin
                if (soft_rst) begin
                    m_clr = 0; m_fill = 0; m_pend = 1'b0;
                    hist.delete();
                end else begin
                    acc    = in_valid && (m_clr >= LEN);
                    m_pend = acc;
                    if (m_clr < LEN) m_clr++;
                    if (acc) begin
                        hist.push_back(int'(in_data));
                        if (hist.size() > LEN) void'(hist.pop_front());
                        if (m_fill < LEN) m_fill++;
                        m_data = window_avg(hist);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Count cycles until in_ready rises, bounded.
    task automatic count_low(output int n);
        n = 0;
        while (in_ready !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
    endtask

    // Present one sample for one cycle; output is visible right after.
    task automatic send(input int v);
        in_valid = 1'b1;
        in_data  = DATA_W'(v);
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        int n;
        reset_n  = 1'b0;
        soft_rst = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        tick(); tick(); tick();
        chk("reset_out_data", int'(out_data), 0);
        chk("reset_primed", int'(primed), 0);
        reset_n = 1'b1;

        // Sweep after reset, with in_valid held high to show it is ignored.
        in_valid = 1'b1;
        in_data  = 16'sd777;
        count_low(n);
        in_valid = 1'b0;
        chk("sweep_len_after_reset", n, 16);

        // 16 back-to-back samples of 1600, then a 17th.
        for (int i = 1; i <= LEN; i++) begin
            in_valid = 1'b1;
            in_data  = 16'sd1600;
            tick();
            chk("ramp_out_data", int'(out_data), 100 * i);
            chk("ramp_out_valid", int'(out_valid), 1);
            chk("ramp_primed", int'(primed), int'(i == LEN));
        end
        send(1600);
        chk("steady_1600", int'(out_data), 1600);

        // Full-scale negative samples with random gaps.
        for (int i = 0; i < LEN; i++) begin
            int gap = $urandom_range(0, 3);
            repeat (gap) tick();
            send(-32768);
        end
        chk("full_negative", int'(out_data), -32768);
        tick();

        // Fresh clear, then floor behaviour for -1 and +1.
        soft_rst = 1'b1;
        tick();
        soft_rst = 1'b0;
        count_low(n);
        chk("sweep_len_soft", n, 16);
        send(-1);
        chk("floor_minus1", int'(out_data), -1);
        send(1);
        chk("floor_sum0", int'(out_data), 0);
        repeat (3) tick();

        // soft_rst together with a sample: dropped, no strobe, full resweep.
        in_valid = 1'b1;
        in_data  = 16'sd555;
        soft_rst = 1'b1;
        tick();
        in_valid = 1'b0;
        soft_rst = 1'b0;
        chk("drop_out_valid", int'(out_valid), 0);
        chk("drop_primed", int'(primed), 0);
        count_low(n);
        chk("sweep_len_drop", n, 16);
        send(160);
        chk("single_160", int'(out_data), 10);
        tick();

        // soft_rst held 5 cycles, then re-asserted 7 cycles into the sweep.
        soft_rst = 1'b1;
        repeat (5) tick();
        soft_rst = 1'b0;
        repeat (7) tick();
        chk("mid_sweep_not_ready", int'(in_ready), 0);
        soft_rst = 1'b1;
        tick();
        soft_rst = 1'b0;
        count_low(n);
        chk("sweep_len_restart", n, 16);

        // Asynchronous reset mid-operation: outputs cleared, full sweep again.
        send(800);
        send(800);
        reset_n = 1'b0;
        #2;
        chk("async_out_data", int'(out_data), 0);
        chk("async_in_ready", int'(in_ready), 0);
        tick();
        reset_n = 1'b1;
        count_low(n);
        chk("sweep_len_async", n, 16);
        send(320);
        chk("after_async_320", int'(out_data), 20);

        repeat (3) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mic_moving_avg_filter.md
Name: mic_moving_avg_filter

Overview:
- Boxcar (moving-average) low-pass stage for the microphone sample path, window 2**LOG2_LEN samples.
- Consumes the soft-reset bit from the micFilter reset PIO on soft_rst.
- Feeds averaged samples downstream with a valid strobe.
- Sample storage is cleared by a sweep state machine after any reset, so the ring can be inferred as RAM.

Parameters:
- DATA_W, 16, signed sample width in bits for both input and output.
- LOG2_LEN, 4, log2 of the window length; LEN = 2**LOG2_LEN = 16.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset, asynchronous, active-low.
- soft_rst  in  1  synchronous, active-high filter reset driven by the PIO out_port bit (same clk domain).
- in_valid  in  1  input sample strobe.
- in_data  in  DATA_W  signed input sample.
- in_ready  out  1  high when a sample can be accepted.
- out_valid  out  1  one-cycle strobe for an averaged result.
- out_data  out  DATA_W  signed average.
- primed  out  1  high once LEN samples have been accepted since the last clear.

Behaviour:
- Reset values (reset_n low): state=CLEAR, clr_ptr=0, wr_ptr=0, sum=0, fill_cnt=0, in_ready=0, out_valid=0, out_data=0, primed=0.
- The ring buffer has no reset; it is zeroed only by the CLEAR sweep.

State CLEAR:
- Each cycle writes 0 to ring[clr_ptr], then increments clr_ptr.
- in_ready=0; in_valid is ignored and no sample is lost-counted.
- After the write to index LEN-1 with soft_rst low, go to RUN next cycle. CLEAR therefore lasts exactly LEN cycles after the later of reset_n release or soft_rst fall.

State RUN:
- in_ready=1.
- A sample is accepted when in_valid && in_ready. On accept:
  - old = ring[wr_ptr] (combinational read);
  - ring[wr_ptr] = in_data;
  - sum = sum + in_data - old;
  - wr_ptr = wr_ptr+1, mod LEN;
  - fill_cnt increments and saturates at LEN.
- Latency is 1 cycle. Next cycle: out_valid=1 and out_data = (updated sum) >>> LOG2_LEN, an arithmetic shift (floor toward -inf).
- out_valid is low in every cycle that does not follow an accept. out_data holds its last value when out_valid is low.
- Gaps between samples of any length are allowed; back-to-back accepts every cycle are supported.

Widths:
- sum is signed DATA_W+LOG2_LEN bits and cannot overflow; no saturation logic is required.
- Before primed, the missing samples contribute 0 (the ring was cleared). Early outputs are therefore scaled down, not renormalised.
- primed = (fill_cnt == LEN), registered.

soft_rst:
- Checked in every state with priority over accept.
- While high: state=CLEAR, clr_ptr=0, wr_ptr=0, sum=0, fill_cnt=0, primed=0, out_valid=0, in_ready=0. A sample presented in that cycle is dropped.
- Holding soft_rst high keeps the block in CLEAR with clr_ptr pinned at 0.
- A pulse in mid-sweep restarts the sweep from 0.
- An output strobe pending for the cycle soft_rst rises is suppressed.
- Async reset mid-operation: identical end state to soft_rst, then a full LEN-cycle sweep.

Decomposition:
- Package mic_filter_pkg holds:
  - DATA_W and LOG2_LEN defaults;
  - derived LEN and SUM_W = DATA_W+LOG2_LEN;
  - the state enum {CLEAR, RUN}.
- One natural sub-module: mic_sample_ring, an LEN x DATA_W ring with one synchronous write port and an asynchronous read port, no reset.
- Control, accumulator and output registers stay in the top level.

Test Plan:
- Release reset_n, soft_rst=0 -> in_ready=0 for exactly 16 cycles, then 1. in_valid pulses during the sweep produce no out_valid.
- 16 back-to-back samples of 1600 -> out_data=100,200,...,1600 on consecutive cycles. primed rises the cycle after the 16th accept. A 17th sample of 1600 gives 1600.
- Primed at 1600, then 16 samples of -32768 with random 0-3 cycle gaps -> final out_data=-32768, no wrap. out_valid count equals accept count.
- After a clear, one sample of -1 -> out_data=-1 (floor). Then one sample of +1 -> out_data=0.
- Mid-stream soft_rst pulsed 1 cycle together with in_valid -> that sample is dropped, out_valid=0 next cycle, in_ready low 16 cycles, primed=0. A following single 160 gives out_data=10.
- soft_rst held 5 cycles, then asserted again 7 cycles into the sweep -> in_ready stays 0 until 16 cycles after the last soft_rst fall.
